// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

  // Sequencer states; 2-bit encoding keeps the state register minimal.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits needed for a bit counter that can represent 0..w without wrapping.
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder slice built from two half adders plus an OR of their carries.
// Latency: purely combinational.
// Backpressure: none; the slice is evaluated every cycle.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .x (a),
    .y (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .x (s0),
    .y (cin),
    .s (s),
    .c (c1)
  );

  // At most one of the two half-adder carries can be set, so OR is the majority.
  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: sums two WIDTH-bit operands LSB-first through one full-adder slice.
// Latency: done pulses WIDTH cycles after the accepting edge; sum/carry_out hold until the next accept.
// Backpressure: start is sampled only in IDLE or DONE; start during SHIFT is dropped, not queued.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    count_q, count_d;

  logic             bit_s;
  logic             bit_c;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (c_q),
    .s    (bit_s),
    .cout (bit_c)
  );

  // Next-state and datapath update; every register holds unless a state acts on it.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    c_d      = c_q;
    count_d  = count_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Accepting a new operation clears the previous result and carry.
          state_d  = SHIFT;
          a_sr_d   = a;
          b_sr_d   = b;
          sum_sr_d = '0;
          c_d      = 1'b0;
          count_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        a_sr_d             = a_sr_q >> 1;
        b_sr_d             = b_sr_q >> 1;
        sum_sr_d           = sum_sr_q >> 1;
        sum_sr_d[WIDTH-1]  = bit_s;
        c_d                = bit_c;
        count_d            = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset overrides any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      c_q      <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      c_q      <= c_d;
      count_q  <= count_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign sum       = sum_sr_q;
  assign carry_out = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with an expected-result queue.
// Latency: results are compared in the DONE cycle.
// Backpressure: start pulses during SHIFT are driven on purpose and must be ignored.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks;
  int errors;
  int done_cnt;

  logic [W:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one start cycle; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit expect_res);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_res) exp_q.push_back({1'b0, x} + {1'b0, y});
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Wait (bounded) for done; compare against the oldest expected result.
  task automatic wait_result(input string tag, output int busy_cycles);
    logic       got;
    logic [W:0] e;
    got         = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
      check({tag, "_carry"}, 32'(carry_out), 32'(e[W]));
    end
  endtask

  initial begin
    int n;
    int d0;
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic add: 8 busy cycles, one done pulse, result holds afterwards
    d0 = done_cnt;
    start_op(8'h5A, 8'h3C, 1'b1);
    wait_result("basic", n);
    check("basic_busy_cycles", 32'(n), 32'd8);
    @(negedge clk);
    check("basic_done_single", 32'(done), 32'd0);
    check("basic_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("basic_sum_hold", 32'(sum), 32'h96);
    check("basic_pulses", 32'(done_cnt - d0), 32'd1);

    // Carry ripple patterns
    start_op(8'hFF, 8'h01, 1'b1);
    wait_result("ripple_ff01", n);
    start_op(8'h80, 8'h80, 1'b1);
    wait_result("ripple_8080", n);

    // No-carry patterns; previous carry_out was 1 and must not leak in
    start_op(8'hAA, 8'h55, 1'b1);
    wait_result("nocarry_aa55", n);
    start_op(8'hFF, 8'h01, 1'b1);
    wait_result("ripple_again", n);
    start_op(8'h00, 8'h00, 1'b1);
    wait_result("nocarry_zero", n);

    // Start pulsed mid-operation is ignored
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    start_op(8'h5A, 8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    a     = 8'h11;
    b     = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result("ignored_start", n);
    repeat (12) @(negedge clk);
    check("ignored_pulses", 32'(done_cnt - d0), 32'd1);
    check("ignored_idle", 32'(busy), 32'd0);

    // Back-to-back: start held during the DONE cycle
    start_op(8'h40, 8'h41, 1'b1);
    wait_result("b2b_first", n);
    a     = 8'h01;
    b     = 8'h02;
    start = 1'b1;
    exp_q.push_back(9'h003);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_now", 32'(busy), 32'd1);
    wait_result("b2b_second", n);
    check("b2b_busy_cycles", 32'(n), 32'd8);

    // Reset mid-operation at bit 4 of 0xFF+0x01
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    start_op(8'hFF, 8'h01, 1'b0);
    repeat (4) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_carry", 32'(carry_out), 32'd0);
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    start_op(8'h10, 8'h20, 1'b1);
    wait_result("after_rst", n);
    check("after_rst_busy_cycles", 32'(n), 32'd8);

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
